// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, field positions and immediate helpers for the tiny CPU
package cpu_pkg;

   localparam int XLEN  = 16;
   localparam int PC_W  = 8;
   localparam int NREG  = 8;
   localparam int RA_W  = $clog2(NREG);
   localparam int DEPTH = 1 << PC_W;

   // instruction field positions
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 9;
   localparam int RS_HI = 8;
   localparam int RS_LO = 6;
   localparam int RT_HI = 5;
   localparam int RT_LO = 3;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_SLT  = 4'h6,
      OP_ADDI = 4'h7,
      OP_LI   = 4'h8,
      OP_LW   = 4'h9,
      OP_SW   = 4'hA,
      OP_BEQ  = 4'hB,
      OP_BNE  = 4'hC,
      OP_JMP  = 4'hD,
      OP_SHL  = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
      return {{(XLEN-6){v[5]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
      return {{(XLEN-9){v[8]}}, v};
   endfunction

endpackage

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - register-file access bus between the CPU datapath and the register file
// master (cpu): drives read addresses w_ra1/w_ra2, write port w_we/w_wa/w_wd; receives w_rd1/w_rd2
// slave (reg_file): the reverse
interface cpu_if;
   import cpu_pkg::*;

   logic [RA_W-1:0] w_ra1;
   logic [RA_W-1:0] w_ra2;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;
   logic            w_we;
   logic [RA_W-1:0] w_wa;
   logic [XLEN-1:0] w_wd;

   modport master (output w_ra1, w_ra2, w_we, w_wa, w_wd, input w_rd1, w_rd2);
   modport slave  (input w_ra1, w_ra2, w_we, w_wa, w_wd, output w_rd1, w_rd2);

endinterface

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - 256x16 instruction memory, combinational read, loaded from outside the CPU
// i_addr : word address (the PC)
// o_data : instruction at i_addr
module inst_mem
   import cpu_pkg::*;
(
   input  logic [PC_W-1:0] i_addr,
   output logic [XLEN-1:0] o_data
);

   // no write port and no reset: contents are placed here before the CPU runs
   reg [XLEN-1:0] mem [0:DEPTH-1];

   assign o_data = mem[i_addr];

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - eight 16-bit registers, two combinational read ports, one write port
// i_clk   : clock, write on rising edge
// i_rst_n : asynchronous active-low clear of all registers
// bus     : cpu_if slave modport carrying read/write addresses and data
module reg_file
   import cpu_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   cpu_if.slave   bus
);

   logic [XLEN-1:0] reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7;
   logic [XLEN-1:0] w_regs [0:NREG-1];

   assign w_regs[0] = reg_0;
   assign w_regs[1] = reg_1;
   assign w_regs[2] = reg_2;
   assign w_regs[3] = reg_3;
   assign w_regs[4] = reg_4;
   assign w_regs[5] = reg_5;
   assign w_regs[6] = reg_6;
   assign w_regs[7] = reg_7;

   // reads see the pre-edge value, so rs==rd instructions use the old contents
   assign bus.w_rd1 = w_regs[bus.w_ra1];
   assign bus.w_rd2 = w_regs[bus.w_ra2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         reg_0 <= '0;
         reg_1 <= '0;
         reg_2 <= '0;
         reg_3 <= '0;
         reg_4 <= '0;
         reg_5 <= '0;
         reg_6 <= '0;
         reg_7 <= '0;
      end else if (bus.w_we) begin
         case (bus.w_wa)
            3'd0: reg_0 <= bus.w_wd;
            3'd1: reg_1 <= bus.w_wd;
            3'd2: reg_2 <= bus.w_wd;
            3'd3: reg_3 <= bus.w_wd;
            3'd4: reg_4 <= bus.w_wd;
            3'd5: reg_5 <= bus.w_wd;
            3'd6: reg_6 <= bus.w_wd;
            3'd7: reg_7 <= bus.w_wd;
         endcase
      end
   end

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle 16-bit tiny CPU: PC, decode, ALU, data memory
// clk    : clock, all state updates on the rising edge
// nRESET : asynchronous active-low reset, clears PC and registers
module cpu
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic nRESET
);

   logic [PC_W-1:0] r_pc;
   logic [XLEN-1:0] r_dmem [0:DEPTH-1];

   logic [XLEN-1:0] w_inst;
   opcode_t         w_op;
   logic [RA_W-1:0] w_rd_a, w_rs_a, w_rt_a;
   logic [XLEN-1:0] w_imm6, w_imm9;
   logic [XLEN-1:0] w_a, w_b;
   logic [PC_W-1:0] w_daddr, w_br_tgt, w_pc_next;
   logic [XLEN-1:0] w_wd;
   logic            w_we, w_dm_we, w_use_rd;

   cpu_if rf_bus ();

   inst_mem imem (
      .i_addr (r_pc),
      .o_data (w_inst)
   );

   reg_file ireg_file (
      .i_clk   (clk),
      .i_rst_n (nRESET),
      .bus     (rf_bus.slave)
   );

   assign w_op   = opcode_t'(w_inst[OP_HI:OP_LO]);
   assign w_rd_a = w_inst[RD_HI:RD_LO];
   assign w_rs_a = w_inst[RS_HI:RS_LO];
   assign w_rt_a = w_inst[RT_HI:RT_LO];
   assign w_imm6 = sext6(w_inst[5:0]);
   assign w_imm9 = sext9(w_inst[8:0]);

   // SW stores rd and the branches compare rd, so port 2 reads rd for those
   assign w_use_rd = (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_BNE);

   assign rf_bus.w_ra1 = w_rs_a;
   assign rf_bus.w_ra2 = w_use_rd ? w_rd_a : w_rt_a;
   assign rf_bus.w_wa  = w_rd_a;
   assign rf_bus.w_wd  = w_wd;
   assign rf_bus.w_we  = w_we;
   assign w_a          = rf_bus.w_rd1;
   assign w_b          = rf_bus.w_rd2;

   // only the low 8 bits of rs+imm6 address dmem, so add at that width
   assign w_daddr  = w_a[PC_W-1:0] + w_imm6[PC_W-1:0];
   assign w_br_tgt = r_pc + 8'd1 + w_imm6[PC_W-1:0];

   always_comb begin
      w_we      = 1'b0;
      w_wd      = '0;
      w_dm_we   = 1'b0;
      w_pc_next = r_pc + 8'd1;
      case (w_op)
         OP_NOP:  ;
         OP_ADD:  begin w_we = 1'b1; w_wd = w_a + w_b; end
         OP_SUB:  begin w_we = 1'b1; w_wd = w_a - w_b; end
         OP_AND:  begin w_we = 1'b1; w_wd = w_a & w_b; end
         OP_OR:   begin w_we = 1'b1; w_wd = w_a | w_b; end
         OP_XOR:  begin w_we = 1'b1; w_wd = w_a ^ w_b; end
         OP_SLT:  begin w_we = 1'b1; w_wd = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))}; end
         OP_ADDI: begin w_we = 1'b1; w_wd = w_a + w_imm6; end
         OP_LI:   begin w_we = 1'b1; w_wd = w_imm9; end
         OP_LW:   begin w_we = 1'b1; w_wd = r_dmem[w_daddr]; end
         OP_SW:   w_dm_we = 1'b1;
         OP_BEQ:  if (w_b == w_a) w_pc_next = w_br_tgt;
         OP_BNE:  if (w_b != w_a) w_pc_next = w_br_tgt;
         OP_JMP:  w_pc_next = w_inst[PC_W-1:0];
         OP_SHL:  begin w_we = 1'b1; w_wd = w_a << w_imm6[3:0]; end
         OP_HALT: w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) r_pc <= '0;
      else         r_pc <= w_pc_next;
   end

   // data memory keeps its contents across reset
   always_ff @(posedge clk) begin
      if (w_dm_we) r_dmem[w_daddr] <= w_b;
   end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for the tiny CPU: table-driven register checks plus reset/halt sequences
module tb_cpu;

   logic clk    = 1'b0;
   logic nRESET = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      string       name;
      int          ridx;
      logic [15:0] exp;
   } chk_t;

   chk_t tab[$];

   cpu dut (
      .clk    (clk),
      .nRESET (nRESET)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] get_reg(input int i);
      case (i)
         0: return dut.ireg_file.reg_0;
         1: return dut.ireg_file.reg_1;
         2: return dut.ireg_file.reg_2;
         3: return dut.ireg_file.reg_3;
         4: return dut.ireg_file.reg_4;
         5: return dut.ireg_file.reg_5;
         6: return dut.ireg_file.reg_6;
         default: return dut.ireg_file.reg_7;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h required 0x%04h", name, act, exp);
      end
   endtask

   function automatic void add(input string name, input int ridx, input logic [15:0] exp);
      chk_t c;
      c.name = name;
      c.ridx = ridx;
      c.exp  = exp;
      tab.push_back(c);
   endfunction

   task automatic apply_table();
      foreach (tab[i]) check(tab[i].name, get_reg(tab[i].ridx), tab[i].exp);
      tab.delete();
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input int low6);
      logic [5:0] v;
      v = low6[5:0];
      return {op, rd, rs, v};
   endfunction

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] enc_li(input logic [2:0] rd, input int imm);
      logic [8:0] v;
      v = imm[8:0];
      return {4'h8, rd, v};
   endfunction

   function automatic logic [15:0] enc_jmp(input logic [7:0] addr);
      return {4'hD, 4'h0, addr};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.imem.mem[i] = 16'hF000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRESET = 1'b0;
      @(negedge clk);
      nRESET = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // program A: arithmetic and LI sign extension
      clear_imem();
      dut.imem.mem[0] = enc_li(3'd1, 5);
      dut.imem.mem[1] = enc_li(3'd2, 3);
      dut.imem.mem[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
      dut.imem.mem[3] = enc_r(4'h2, 3'd4, 3'd2, 3'd1);
      dut.imem.mem[4] = enc_li(3'd5, -1);
      dut.imem.mem[5] = 16'hF000;

      #3 nRESET = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), get_reg(i), 16'h0000);
      check("reset_pc", {8'h00, dut.r_pc}, 16'h0000);
      @(negedge clk);
      nRESET = 1'b1;
      run(1);
      check("first_edge_pc", {8'h00, dut.r_pc}, 16'h0001);
      check("first_edge_r1", get_reg(1), 16'h0005);
      check("first_edge_r2", get_reg(2), 16'h0000);
      run(9);
      add("A_r1", 1, 16'h0005);
      add("A_r2", 2, 16'h0003);
      add("A_add_r3", 3, 16'h0008);
      add("A_sub_r4", 4, 16'hFFFE);
      add("A_li_neg_r5", 5, 16'hFFFF);
      add("A_r0", 0, 16'h0000);
      apply_table();
      check("A_halt_pc", {8'h00, dut.r_pc}, 16'h0005);

      // program B: counted loop with BNE, then HALT
      clear_imem();
      dut.imem.mem[0] = enc_li(3'd1, 0);
      dut.imem.mem[1] = enc_li(3'd2, 3);
      dut.imem.mem[2] = enc(4'h7, 3'd1, 3'd1, 1);
      dut.imem.mem[3] = enc(4'hC, 3'd1, 3'd2, -2);
      dut.imem.mem[4] = 16'hF000;
      do_reset();
      run(14);
      add("B_loop_r1", 1, 16'h0003);
      add("B_r2", 2, 16'h0003);
      add("B_r3_cleared", 3, 16'h0000);
      apply_table();
      check("B_halt_pc", {8'h00, dut.r_pc}, 16'h0004);
      run(20);
      check("B_stable_r1", get_reg(1), 16'h0003);
      check("B_stable_r2", get_reg(2), 16'h0003);
      check("B_stable_pc", {8'h00, dut.r_pc}, 16'h0004);

      // program C: memory, jump, SLT, SHL, BEQ, write to r0
      clear_imem();
      dut.imem.mem[0]  = enc_li(3'd1, 16'h55);
      dut.imem.mem[1]  = enc(4'hA, 3'd1, 3'd0, 4);
      dut.imem.mem[2]  = enc(4'h9, 3'd6, 3'd0, 4);
      dut.imem.mem[3]  = enc_jmp(8'd5);
      dut.imem.mem[4]  = enc_li(3'd7, 1);
      dut.imem.mem[5]  = enc_li(3'd2, -1);
      dut.imem.mem[6]  = enc_li(3'd3, 1);
      dut.imem.mem[7]  = enc_r(4'h6, 3'd4, 3'd2, 3'd3);
      dut.imem.mem[8]  = enc_li(3'd5, 3);
      dut.imem.mem[9]  = enc(4'hE, 3'd5, 3'd5, 4);
      dut.imem.mem[10] = enc(4'hB, 3'd1, 3'd1, 1);
      dut.imem.mem[11] = enc_li(3'd7, 2);
      dut.imem.mem[12] = enc_r(4'h1, 3'd0, 3'd1, 3'd1);
      dut.imem.mem[13] = 16'hF000;
      do_reset();
      run(20);
      add("C_lw_r6", 6, 16'h0055);
      add("C_jmp_skip_r7", 7, 16'h0000);
      add("C_slt_r4", 4, 16'h0001);
      add("C_shl_r5", 5, 16'h0030);
      add("C_r0_written", 0, 16'h00AA);
      add("C_r2", 2, 16'hFFFF);
      apply_table();
      check("C_halt_pc", {8'h00, dut.r_pc}, 16'h000D);

      // mid-run asynchronous reset and restart from mem[0]
      do_reset();
      run(5);
      check("mid_pre_r1", get_reg(1), 16'h0055);
      check("mid_pre_r6", get_reg(6), 16'h0055);
      @(negedge clk);
      #2 nRESET = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("mid_async_r%0d", i), get_reg(i), 16'h0000);
      check("mid_async_pc", {8'h00, dut.r_pc}, 16'h0000);
      @(negedge clk);
      nRESET = 1'b1;
      run(1);
      check("restart_pc", {8'h00, dut.r_pc}, 16'h0001);
      check("restart_r1", get_reg(1), 16'h0055);
      check("restart_r6", get_reg(6), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu.md
# cpu

Single-cycle 16-bit tiny processor: the top-level block of the tiny-CPU design, with no external ports other than clock and reset. It holds an instruction memory loaded externally before or during reset, eight general-purpose 16-bit registers, a data memory and an 8-bit PC. It executes one instruction per clock.

## Interface
- No parameters. Fixed values: instruction and data width 16, imem and dmem depth 256 words, 8 registers.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `nRESET`  input  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low).
- Required hierarchy, probed by name in verification:
  - instance `imem` containing `reg [15:0] mem [0:255]`;
  - instance `ireg_file` containing `reg [15:0] reg_0` … `reg_7`.

## Operation
- Fields:
  - op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3];
  - imm6=[5:0], sign-extended;
  - imm9=[8:0], sign-extended;
  - addr8=[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt.
  - 2 SUB rd=rs−rt.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT rd=(signed rs<rt)?1:0.
  - 7 ADDI rd=rs+imm6.
  - 8 LI rd=imm9.
  - 9 LW rd=dmem[(rs+imm6)[7:0]].
  - A SW dmem[(rs+imm6)[7:0]]=rd.
  - B BEQ: if rd==rs then PC=PC+1+imm6.
  - C BNE: if rd!=rs then PC=PC+1+imm6.
  - D JMP PC=addr8.
  - E SHL rd=rs<<imm6[3:0].
  - F HALT: PC holds, no writes.
- Arithmetic:
  - Modulo 2^16, no flags.
  - PC arithmetic is modulo 256; wrap from 255 to 0.
  - Default next PC = PC+1.
- reg_0 is an ordinary writable register, not hardwired to zero.
- Operand reads are combinational. When a source register equals the destination, the old value is used.
- imem: combinational read at PC; no write port inside the CPU; not cleared by reset.
- dmem: 256×16, combinational read, synchronous write; not reset (contents undefined until written).

## Timing
- Reset asserted: PC=0 and reg_0..reg_7=0, immediately (asynchronous). Reset has priority over everything.
- Reset release: the instruction at mem[0] takes effect at the first rising edge with nRESET=1.
- Each instruction completes in one cycle. Register, dmem and PC updates land on the same edge.
- A result is visible to the next instruction.
- Taken branch or jump: the target executes on the next cycle. No delay slot, no stall.
- HALT: state is frozen until reset. Reset mid-run restarts from PC=0 with cleared registers; imem and dmem are kept.

## Structure
- Shared package `cpu_pkg`: opcode constants, field positions, `XLEN=16`, `PC_W=8`, `NREG=8`.
- Sub-modules:
  - `reg_file` (instance `ireg_file`): 8×16 registers with two read ports, one write port, async reset.
  - `inst_mem` (instance `imem`).
  - ALU and control logic live in `cpu`.

## Test plan
- Reset: hold nRESET low, then release → all registers 0 and PC 0; the first edge executes mem[0].
- Sequence LI r1,5; LI r2,3; ADD r3,r1,r2; SUB r4,r2,r1 → r3=8, r4=0xFFFE; LI r5,-1 → r5=0xFFFF.
- Loop: LI r1,0; LI r2,3; ADDI r1,r1,1; BNE r1,r2,−2; HALT → r1=3; then state is stable for 20 cycles.
- Memory: LI r1,0x55; SW r1,[r0+4]; LW r6,[r0+4] → r6=0x0055.
- JMP past an LI r7,1 → r7 remains 0. SLT with −1 vs 1 gives 1. SHL by 4 of 0x0003 gives 0x0030.
- Assert nRESET mid-program → registers clear at once, without waiting for a clock edge; execution restarts at mem[0].
